byte_reg_write_arbiter: RTL

- Shares the write port of one byte-enabled data register between NREQ requesters.
- Each requester presents data plus per-byte enables and holds its request for as many beats as it needs.
- The arbiter grants one requester at a time, using round-robin rotation with a bounded hold.
- It drives registered d/byteena/write-enable outputs straight into the register's write port.

---
 rtl/byte_reg_write_arbiter_pkg.sv | 24 ++
 rtl/byte_reg_write_arbiter_if.sv | 36 +++
 rtl/byte_reg_rr_pick.sv | 53 +++++
 rtl/byte_reg_write_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/byte_reg_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// byte_reg_arb_pkg
// Shared types and sizing helpers for the byte-enabled register write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   be_width    : byte-enable width for a given data width
//   cnt_width   : width of the per-grant beat counter (clog2(MAX_HOLD), min 1)
// -----------------------------------------------------------------------------
package byte_reg_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int unsigned be_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // The counter only has to reach MAX_HOLD-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/byte_reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// byte_reg_write_arbiter_if
// Requester bundle plus the register write port driven by the arbiter.
//   req, wdata, wbe            : from the requesters (flattened, requester i
//                                at [i*DW +: DW] and [i*(DW/8) +: DW/8])
//   gnt                        : one-hot grant back to the requesters
//   reg_we, reg_byteena, reg_d : registered write port of the data register
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface byte_reg_write_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 16
);
    import byte_reg_arb_pkg::*;

    localparam int unsigned BEW = be_width(DW);

    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ*BEW-1:0] wbe;
    logic [NREQ-1:0]     gnt;
    logic                reg_we;
    logic [BEW-1:0]      reg_byteena;
    logic [DW-1:0]       reg_d;

    modport master (
        output req, wdata, wbe,
        input  gnt, reg_we, reg_byteena, reg_d
    );

    modport slave (
        input  req, wdata, wbe,
        output gnt, reg_we, reg_byteena, reg_d
    );

endinterface

// File: rtl/byte_reg_rr_pick.sv
// -----------------------------------------------------------------------------
// byte_reg_rr_pick
// Combinational winner selection.
//   req    : request vector
//   start  : round-robin start index (highest priority this round)
//   winner : one-hot winner, zero when nothing requests
//   valid  : any request present
// Build option: ARB_FIXED_PRIO_EN selects lowest-index-wins, start is ignored.
// -----------------------------------------------------------------------------
module byte_reg_rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned PW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   start,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    assign valid = |req;

`ifdef ARB_FIXED_PRIO_EN

    logic unused_start;
    assign unused_start = ^start;

    // Isolate the lowest set bit.
    assign winner = req & (~req + NREQ'(1));

`else

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] win_rot;
    logic            found;

    always_comb begin
        // Rotate right by start so that bit 0 is the highest-priority slot.
        rot     = NREQ'({req, req} >> start);
        win_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (rot[i] && !found) begin
                win_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Rotate the one-hot result back left by start.
        winner = NREQ'(({win_rot, win_rot} << start) >> NREQ);
    end

`endif

endmodule

// File: rtl/byte_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// byte_reg_write_arbiter
// Shares the write port of one byte-enabled register between NREQ requesters.
// Round-robin grant with a bounded hold of MAX_HOLD beats while others wait;
// an uncontested owner keeps the grant for as long as it requests.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : byte_reg_write_arbiter_if.slave (req/wdata/wbe in, gnt and the
//            registered reg_we/reg_byteena/reg_d out)
// Build option: ARB_FIXED_PRIO_EN switches to fixed priority (lowest index
// wins, hold limit only yields to a lower-index requester).
// -----------------------------------------------------------------------------
module byte_reg_write_arbiter
    import byte_reg_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    byte_reg_write_arbiter_if.slave   bus
);

    localparam int unsigned BEW = be_width(DW);
    localparam int unsigned PW  = $clog2(NREQ);
    localparam int unsigned CW  = cnt_width(MAX_HOLD);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            reg_we_q, reg_we_d;
    logic [BEW-1:0]  reg_be_q, reg_be_d;
    logic [DW-1:0]   reg_d_q, reg_d_d;

    logic [PW-1:0]   owner;
    logic [PW-1:0]   ptr_after;
    logic [DW-1:0]   sel_d;
    logic [BEW-1:0]  sel_be;
    logic            owner_req;
    logic            accept;
    logic            compete;
    logic            release_gnt;
    logic [NREQ-1:0] pick_req;
    logic [PW-1:0]   pick_start;
    logic [NREQ-1:0] pick_win;
    logic            pick_valid;

    // Owner index and its data/enables, taken from the one-hot grant.
    always_comb begin
        owner  = '0;
        sel_d  = '0;
        sel_be = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner  = PW'(i);
                sel_d  = bus.wdata[i*DW +: DW];
                sel_be = bus.wbe[i*BEW +: BEW];
            end
        end
    end

    assign ptr_after = (owner == PTR_LAST) ? '0 : owner + PW'(1);
    assign owner_req = |(gnt_q & bus.req);
    assign accept    = (state_q == GRANT) && owner_req;

`ifdef ARB_FIXED_PRIO_EN
    // gnt_q - 1 masks every index below the one-hot owner.
    assign compete = |(bus.req & (gnt_q - NREQ'(1)));
`else
    assign compete = |(bus.req & ~gnt_q);
`endif

    assign release_gnt = (state_q == GRANT) &&
                         (!owner_req || (accept && (cnt_q == HOLD_LAST) && compete));

    // On release the owner is excluded so the grant always moves on.
    assign pick_req   = (state_q == IDLE) ? bus.req : (bus.req & ~gnt_q);
    assign pick_start = (state_q == IDLE) ? ptr_q : ptr_after;

    byte_reg_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .winner (pick_win),
        .valid  (pick_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        reg_we_d = 1'b0;
        reg_be_d = reg_be_q;
        reg_d_d  = reg_d_q;

        if (accept) begin
            reg_d_d  = sel_d;
            reg_be_d = sel_be;
            reg_we_d = |sel_be;
            // Saturate so an uncontested owner yields on its next beat once
            // a competitor shows up.
            if (cnt_q != HOLD_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_win;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    ptr_d   = ptr_after;
                    gnt_d   = pick_win;
                    cnt_d   = '0;
                    state_d = pick_valid ? GRANT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            reg_we_q <= 1'b0;
            reg_be_q <= '0;
            reg_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            reg_we_q <= reg_we_d;
            reg_be_q <= reg_be_d;
            reg_d_q  <= reg_d_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_byteena = reg_be_q;
    assign bus.reg_d       = reg_d_q;

endmodule
